// File: rtl/cpu_instr_sequencer_pkg.sv
// Shared definitions for the CPU instruction sequencer: opcodes, instruction
// field layout, FSM states and pin-encoding helpers.
package cpu_seq_pkg;

  localparam int INSTR_W    = 13;
  localparam int OPCODE_LSB = 9;
  localparam int OPCODE_W   = 4;
  localparam int DATA_LSB   = 5;
  localparam int DATA_W     = 4;
  localparam int ADDR_LSB   = 1;
  localparam int ADDR_W     = 4;
  localparam int WE_BIT     = 0;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_STORE = 4'h2,
    OP_LOAD  = 4'h3,
    OP_AND   = 4'h5,
    OP_OR    = 4'h6,
    OP_XOR   = 4'h7,
    OP_NOT   = 4'h8,
    OP_SHL   = 4'h9,
    OP_NOP   = 4'hF
  } opcode_e;

  typedef logic [INSTR_W-1:0] instr_t;

  localparam instr_t NOP_INSTR = {OP_NOP, 4'h0, 4'h0, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_DONE
  } state_e;

  function automatic logic [7:0] ui_pins(instr_t i);
    return {i[DATA_LSB +: DATA_W], i[ADDR_LSB +: ADDR_W]};
  endfunction

  function automatic logic [7:0] uio_pins(instr_t i);
    return {i[OPCODE_LSB +: OPCODE_W], 3'b000, i[WE_BIT]};
  endfunction

endpackage

// File: rtl/cpu_instr_sequencer_if.sv
// Host-side bus of the instruction sequencer: program load, run control,
// CPU pin drive/capture and result readback.
interface cpu_instr_sequencer_if #(parameter int AW = 4);

  logic          prog_wr_en;
  logic [AW-1:0] prog_wr_addr;
  logic [12:0]   prog_wr_data;
  logic          start;
  logic [AW:0]   run_len;
  logic          abort;
  logic [3:0]    acc_in;
  logic [7:0]    cpu_ui;
  logic [7:0]    cpu_uio;
  logic [AW-1:0] res_rd_addr;
  logic [3:0]    res_rd_data;
  logic [3:0]    last_result;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;

  modport master (
    output prog_wr_en, prog_wr_addr, prog_wr_data, start, run_len, abort,
           acc_in, res_rd_addr,
    input  cpu_ui, cpu_uio, res_rd_data, last_result, pc, busy, done
  );

  modport slave (
    input  prog_wr_en, prog_wr_addr, prog_wr_data, start, run_len, abort,
           acc_in, res_rd_addr,
    output cpu_ui, cpu_uio, res_rd_data, last_result, pc, busy, done
  );

endinterface

// File: rtl/cpu_instr_sequencer_prog_mem.sv
// Program store: DEPTH x 13-bit register file, synchronous write,
// asynchronous read, synchronous reset of every entry to NOP.
module cpu_seq_prog_mem
  import cpu_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  instr_t        wr_data,
  input  logic [AW-1:0] rd_addr,
  output instr_t        rd_data
);

  instr_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= NOP_INSTR;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cpu_instr_sequencer.sv
// Plays a stored program onto the CPU pins with HOLD/SETTLE spacing and
// captures the accumulator after each instruction into a result file.
module cpu_instr_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int HOLD   = 2,
  parameter int SETTLE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_instr_sequencer_if.slave bus
);

  localparam int CW = $clog2((HOLD > SETTLE ? HOLD : SETTLE) + 1);

  state_e        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] pc;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [7:0]    ui_reg;
  logic [7:0]    uio_reg;
  logic [3:0]    last_reg;
  logic [3:0]    results [DEPTH];

  logic          mem_wr_en;
  logic [AW-1:0] fetch_addr;
  instr_t        mem_data;
  instr_t        fetch;

  // Writes are locked out during a run; a write landing on the same edge as
  // start is forwarded so the first instruction sees it.
  assign mem_wr_en  = bus.prog_wr_en & ~busy;
  assign fetch_addr = (state == S_IDLE) ? '0 : pc + AW'(1);
  assign fetch      = (mem_wr_en && bus.prog_wr_addr == fetch_addr) ? bus.prog_wr_data : mem_data;

  cpu_seq_prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_prog_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mem_wr_en),
    .wr_addr (bus.prog_wr_addr),
    .wr_data (bus.prog_wr_data),
    .rd_addr (fetch_addr),
    .rd_data (mem_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pc       <= '0;
      len      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ui_reg   <= ui_pins(NOP_INSTR);
      uio_reg  <= uio_pins(NOP_INSTR);
      last_reg <= '0;
      for (int i = 0; i < DEPTH; i++) results[i] <= '0;
    end else begin
      done <= 1'b0;
      if (bus.abort && busy) begin
        state   <= S_IDLE;
        cnt     <= '0;
        busy    <= 1'b0;
        ui_reg  <= ui_pins(NOP_INSTR);
        uio_reg <= uio_pins(NOP_INSTR);
      end else begin
        unique case (state)
          S_IDLE: begin
            if (bus.start) begin
              len <= bus.run_len;
              pc  <= '0;
              cnt <= '0;
              if (bus.run_len == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state   <= S_ISSUE;
                busy    <= 1'b1;
                ui_reg  <= ui_pins(fetch);
                uio_reg <= uio_pins(fetch);
              end
            end
          end
          S_ISSUE: begin
            if (cnt == CW'(HOLD - 1)) begin
              state   <= S_SETTLE;
              cnt     <= '0;
              ui_reg  <= ui_pins(NOP_INSTR);
              uio_reg <= uio_pins(NOP_INSTR);
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_SETTLE: begin
            if (cnt == CW'(SETTLE - 1)) begin
              results[pc] <= bus.acc_in;
              last_reg    <= bus.acc_in;
              cnt         <= '0;
              if ({1'b0, pc} + (AW+1)'(1) == len) begin
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                pc      <= pc + AW'(1);
                state   <= S_ISSUE;
                ui_reg  <= ui_pins(fetch);
                uio_reg <= uio_pins(fetch);
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.cpu_ui      = ui_reg;
  assign bus.cpu_uio     = uio_reg;
  assign bus.res_rd_data = results[bus.res_rd_addr];
  assign bus.last_result = last_reg;
  assign bus.pc          = pc;
  assign bus.busy        = busy;
  assign bus.done        = done;

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// Randomized scoreboard bench for cpu_instr_sequencer: a per-cycle model of
// the pin schedule feeds a queue that a negedge monitor drains and compares.
module tb_cpu_instr_sequencer;

  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int HOLD   = 2;
  localparam int SETTLE = 3;
  localparam int T      = HOLD + SETTLE;
  localparam logic [12:0] NOP = 13'h1E00;

  typedef struct packed {
    logic [7:0]    ui;
    logic [7:0]    uio;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;
    logic [3:0]    last;
  } cyc_t;

  logic clk = 1'b0;
  logic rst;

  cpu_instr_sequencer_if #(.AW(AW)) bus();

  cpu_instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .HOLD(HOLD), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  cyc_t exp_q[$];

  logic [12:0] mp      [DEPTH];
  logic [3:0]  exp_res [DEPTH];
  logic [3:0]  acc_tab [DEPTH];
  logic [3:0]  exp_last;

  // Monitor: every cycle with an outstanding expectation is compared mid-cycle.
  always @(negedge clk) begin
    cyc_t got, e;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {bus.cpu_ui, bus.cpu_uio, bus.busy, bus.done, bus.pc, bus.last_result};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("[TB] FAIL cycle_outputs @%0t: got ui=%h uio=%h busy=%b done=%b pc=%h last=%h, expected ui=%h uio=%h busy=%b done=%b pc=%h last=%h",
                 $time, got.ui, got.uio, got.busy, got.done, got.pc, got.last,
                 e.ui, e.uio, e.busy, e.done, e.pc, e.last);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      mp[i]      = NOP;
      exp_res[i] = 4'h0;
    end
    exp_last = 4'h0;
  endtask

  task automatic writeProg(input logic [AW-1:0] addr, input logic [12:0] data);
    @(posedge clk); #1;
    bus.prog_wr_en   = 1'b1;
    bus.prog_wr_addr = addr;
    bus.prog_wr_data = data;
    mp[addr]         = data;
    @(posedge clk); #1;
    bus.prog_wr_en = 1'b0;
  endtask

  task automatic readBack();
    for (int a = 0; a < DEPTH; a++) begin
      bus.res_rd_addr = AW'(a);
      #1;
      checkOutput($sformatf("result[%0d]", a), 32'(bus.res_rd_data), 32'(exp_res[a]));
    end
    checkOutput("last_result", 32'(bus.last_result), 32'(exp_last));
  endtask

  // Issues one run and pushes the expected outputs of every cycle it spans.
  // acc_mode: 0 random, 1 table per instruction, 2 instruction index.
  task automatic applyStimulus(input int n, input int abort_at, input bit noise, input int acc_mode,
                               input bit wr_same, input logic [AW-1:0] wr_addr,
                               input logic [12:0] wr_data, input int rst_at);
    cyc_t        r;
    int          k, ph, last_cyc;
    logic [3:0]  acc;
    logic [12:0] w;
    last_cyc = n * T + 1;
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.run_len = (AW+1)'(n);
    bus.acc_in  = 4'($urandom);
    if (wr_same) begin
      bus.prog_wr_en   = 1'b1;
      bus.prog_wr_addr = wr_addr;
      bus.prog_wr_data = wr_data;
      mp[wr_addr]      = wr_data;
    end
    for (int c = 1; c <= last_cyc; c++) begin
      @(posedge clk); #1;
      bus.start      = 1'b0;
      bus.prog_wr_en = 1'b0;
      bus.abort      = 1'b0;
      k  = (c - 1) / T;
      ph = (c - 1) % T;
      if (rst_at > 0 && c == rst_at + 1) begin
        rst = 1'b0;
        modelReset();
        exp_q.push_back({8'h00, 8'hF0, 2'b00, {AW{1'b0}}, 4'h0});
        break;
      end
      if (abort_at > 0 && c == abort_at + 1) begin
        exp_q.push_back({8'h00, 8'hF0, 2'b00, AW'((abort_at - 1) / T), exp_last});
        break;
      end
      if (c <= n * T) begin
        w = (ph < HOLD) ? mp[k] : NOP;
        r = {w[8:1], w[12:9], 3'b000, w[0], 1'b1, 1'b0, AW'(k), exp_last};
      end else begin
        r = {8'h00, 8'hF0, 1'b0, 1'b1, AW'((n == 0) ? 0 : n - 1), exp_last};
      end
      exp_q.push_back(r);
      if (c <= n * T && acc_mode == 1)      acc = acc_tab[k];
      else if (c <= n * T && acc_mode == 2) acc = 4'(k);
      else                                  acc = 4'($urandom);
      bus.acc_in = acc;
      if (noise && c <= n * T) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.prog_wr_en   = 1'b1;
          bus.prog_wr_addr = AW'($urandom);
          bus.prog_wr_data = 13'($urandom);
        end
        if ($urandom_range(0, 3) == 0) begin
          bus.start   = 1'b1;
          bus.run_len = (AW+1)'($urandom_range(0, DEPTH));
        end
      end
      if (c == abort_at) bus.abort = 1'b1;
      if (c == rst_at) rst = 1'b1;
      else if (c <= n * T && ph == T - 1 && c != abort_at) begin
        exp_res[k] = acc;
        exp_last   = acc;
      end
    end
  endtask

  initial begin
    int n, ab;
    bus.prog_wr_en   = 1'b0;
    bus.prog_wr_addr = '0;
    bus.prog_wr_data = '0;
    bus.start        = 1'b0;
    bus.run_len      = '0;
    bus.abort        = 1'b0;
    bus.acc_in       = '0;
    bus.res_rd_addr  = '0;
    rst = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_uio", 32'(bus.cpu_uio), 32'h0F0);
    checkOutput("reset_ui", 32'(bus.cpu_ui), 32'h000);
    checkOutput("reset_busy", 32'(bus.busy), 32'h0);
    checkOutput("reset_done", 32'(bus.done), 32'h0);
    checkOutput("reset_pc", 32'(bus.pc), 32'h0);
    checkOutput("reset_last", 32'(bus.last_result), 32'h0);
    rst = 1'b0;
    readBack();

    $display("[TB] basic two-instruction run");
    writeProg(4'd0, {4'h0, 4'h5, 4'h0, 1'b0});
    writeProg(4'd1, {4'h9, 4'h0, 4'h0, 1'b0});
    acc_tab[0] = 4'h5;
    acc_tab[1] = 4'hA;
    applyStimulus(2, 0, 1'b0, 1, 1'b0, '0, '0, 0);
    readBack();
    bus.res_rd_addr = 4'd0; #1;
    checkOutput("basic_result0", 32'(bus.res_rd_data), 32'h5);
    bus.res_rd_addr = 4'd1; #1;
    checkOutput("basic_result1", 32'(bus.res_rd_data), 32'hA);

    $display("[TB] zero-length run");
    applyStimulus(0, 0, 1'b0, 0, 1'b0, '0, '0, 0);

    $display("[TB] abort in cycle 4");
    for (int i = 0; i < 3; i++) writeProg(AW'(i), 13'($urandom));
    applyStimulus(3, 4, 1'b0, 0, 1'b0, '0, '0, 0);
    readBack();

    $display("[TB] collisions");
    applyStimulus(4, 0, 1'b1, 0, 1'b1, 4'd0, 13'h0B5B, 0);
    readBack();
    applyStimulus(4, 0, 1'b0, 0, 1'b0, '0, '0, 0);

    $display("[TB] full depth");
    for (int i = 0; i < DEPTH; i++) writeProg(AW'(i), 13'($urandom));
    applyStimulus(DEPTH, 0, 1'b0, 2, 1'b0, '0, '0, 0);
    readBack();

    $display("[TB] random runs");
    repeat (10) begin
      repeat ($urandom_range(0, 3)) writeProg(AW'($urandom), 13'($urandom));
      n  = $urandom_range(0, DEPTH);
      ab = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n * T) : 0;
      applyStimulus(n, ab, 1'($urandom), 0, 1'($urandom), AW'($urandom), 13'($urandom), 0);
      readBack();
    end

    $display("[TB] reset mid-run");
    applyStimulus(5, 0, 1'b0, 0, 1'b0, '0, '0, 7);
    readBack();
    applyStimulus(1, 0, 1'b0, 0, 1'b0, '0, '0, 0);
    readBack();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checkOutput("queue_drain", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
